vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 113 +++++++++++
 tb/tb_vga_timing_gen.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: free-running pixel/line counters, registered
// sync and blanking flags, and a colour stage that zeroes pixels while blanked.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pix_ce,
  input  logic [3:0] pix_r,
  input  logic [3:0] pix_g,
  input  logic [3:0] pix_b,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       frame_tick,
  output logic       Hsync,
  output logic       Vsync,
  output logic       HBlank,
  output logic       VBlank,
  output logic [3:0] vgaRed,
  output logic [3:0] vgaGreen,
  output logic [3:0] vgaBlue
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS      = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST    = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST    = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [9:0] h_q;
  logic [9:0] v_q;
  logic       h_last;
  logic       v_last;

  assign h_last = (h_q == H_LAST);
  assign v_last = (v_q == V_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; the async reset branch must come first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_q <= '0;
      v_q <= '0;
    end else if (pix_ce) begin
      h_q <= h_last ? '0 : h_q + 10'd1;
      if (h_last) begin
        v_q <= v_last ? '0 : v_q + 10'd1;
      end
    end
  end

  assign hcount = h_q;
  assign vcount = v_q;

  // Counters are already 0 under reset; the explicit gate keeps the tick low
  // even for degenerate one-pixel timings.
  assign frame_tick = h_last && v_last && pix_ce && !reset;

  logic hblank_d;
  logic vblank_d;
  logic hsync_on;
  logic vsync_on;

  always_comb begin
    hblank_d = (h_q >= H_VIS);
    vblank_d = (v_q >= V_VIS);
    hsync_on = (h_q >= HS_FIRST) && (h_q <= HS_LAST);
    vsync_on = (v_q >= VS_FIRST) && (v_q <= VS_LAST);
  end

  // Output stage: one pix_ce behind the counters, so sync, blank and colour
  // all describe the same pixel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      HBlank   <= 1'b1;
      VBlank   <= 1'b1;
      Hsync    <= !SYNC_POL;
      Vsync    <= !SYNC_POL;
      vgaRed   <= '0;
      vgaGreen <= '0;
      vgaBlue  <= '0;
    end else if (pix_ce) begin
      HBlank <= hblank_d;
      VBlank <= vblank_d;
      Hsync  <= hsync_on ? SYNC_POL : !SYNC_POL;
      Vsync  <= vsync_on ? SYNC_POL : !SYNC_POL;
      if (hblank_d || vblank_d) begin
        vgaRed   <= '0;
        vgaGreen <= '0;
        vgaBlue  <= '0;
      end else begin
        vgaRed   <= pix_r;
        vgaGreen <= pix_g;
        vgaBlue  <= pix_b;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: a shrunken 16x11 raster (both sync polarities) checked every
// cycle, plus a default 800x525 instance checked at hand-picked first-line points.
module tb_vga_timing_gen;

  logic       clk;
  logic       reset;
  logic       pix_ce;
  logic [3:0] pix_r, pix_g, pix_b;

  logic [9:0] s0_hcount, s0_vcount, s1_hcount, s1_vcount, d_hcount, d_vcount;
  logic       s0_tick, s0_Hsync, s0_Vsync, s0_HBlank, s0_VBlank;
  logic       s1_tick, s1_Hsync, s1_Vsync, s1_HBlank, s1_VBlank;
  logic       d_tick, d_Hsync, d_Vsync, d_HBlank, d_VBlank;
  logic [3:0] s0_r, s0_g, s0_b, s1_r, s1_g, s1_b, d_r, d_g, d_b;

  // Small raster: H 8+2+3+3 = 16, V 6+1+2+2 = 11, frame = 176 pixels.
  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2), .SYNC_POL(1'b0)
  ) u_s0 (
    .clk(clk), .reset(reset), .pix_ce(pix_ce),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .hcount(s0_hcount), .vcount(s0_vcount), .frame_tick(s0_tick),
    .Hsync(s0_Hsync), .Vsync(s0_Vsync), .HBlank(s0_HBlank), .VBlank(s0_VBlank),
    .vgaRed(s0_r), .vgaGreen(s0_g), .vgaBlue(s0_b)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2), .SYNC_POL(1'b1)
  ) u_s1 (
    .clk(clk), .reset(reset), .pix_ce(pix_ce),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .hcount(s1_hcount), .vcount(s1_vcount), .frame_tick(s1_tick),
    .Hsync(s1_Hsync), .Vsync(s1_Vsync), .HBlank(s1_HBlank), .VBlank(s1_VBlank),
    .vgaRed(s1_r), .vgaGreen(s1_g), .vgaBlue(s1_b)
  );

  vga_timing_gen u_def (
    .clk(clk), .reset(reset), .pix_ce(pix_ce),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .hcount(d_hcount), .vcount(d_vcount), .frame_tick(d_tick),
    .Hsync(d_Hsync), .Vsync(d_Vsync), .HBlank(d_HBlank), .VBlank(d_VBlank),
    .vgaRed(d_r), .vgaGreen(d_g), .vgaBlue(d_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference state for the small raster: counters and the registered outputs.
  int         mh, mv;
  logic       e_hb, e_vb, e_hs, e_vs;
  logic [3:0] e_r, e_g, e_b;
  int         n_ce;
  int         clk_n;
  int         last_tick;
  int         n_ticks;
  int         exp_interval;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    mh = 0; mv = 0;
    e_hb = 1'b1; e_vb = 1'b1; e_hs = 1'b1; e_vs = 1'b1;
    e_r = 4'h0; e_g = 4'h0; e_b = 4'h0;
    n_ce = 0;
  endtask

  // One clk cycle starting and ending on a falling edge.
  task automatic step(input bit ce);
    pix_ce = ce;
    pix_r  = 4'(mh) ^ 4'h5;
    pix_g  = 4'(mv) ^ 4'hA;
    pix_b  = 4'hF;
    #1;
    check("frame_tick", s0_tick, (mh == 15 && mv == 10 && ce));
    check("frame_tick_pol1", s1_tick, (mh == 15 && mv == 10 && ce));
    if (s0_tick) begin
      if (last_tick >= 0) check("tick_interval", clk_n - last_tick, exp_interval);
      last_tick = clk_n;
      n_ticks++;
    end
    @(posedge clk);
    if (ce) begin
      e_hb = (mh >= 8);
      e_vb = (mv >= 6);
      e_hs = !(mh >= 10 && mh <= 12);
      e_vs = !(mv >= 7 && mv <= 8);
      if (e_hb || e_vb) begin
        e_r = 4'h0; e_g = 4'h0; e_b = 4'h0;
      end else begin
        e_r = pix_r; e_g = pix_g; e_b = pix_b;
      end
      if (mh == 15) begin
        mh = 0;
        mv = (mv == 10) ? 0 : mv + 1;
      end else begin
        mh = mh + 1;
      end
      n_ce++;
    end
    clk_n++;
    @(negedge clk);
    check("hcount", s0_hcount, mh);
    check("vcount", s0_vcount, mv);
    check("HBlank", s0_HBlank, e_hb);
    check("VBlank", s0_VBlank, e_vb);
    check("Hsync", s0_Hsync, e_hs);
    check("Vsync", s0_Vsync, e_vs);
    check("vgaRed", s0_r, e_r);
    check("vgaGreen", s0_g, e_g);
    check("vgaBlue", s0_b, e_b);
    check("pol1_Hsync", s1_Hsync, !e_hs);
    check("pol1_Vsync", s1_Vsync, !e_vs);
    check("pol1_hcount", s1_hcount, mh);
    check("pol1_vcount", s1_vcount, mv);
    check("pol1_HBlank", s1_HBlank, e_hb);
    check("pol1_VBlank", s1_VBlank, e_vb);
    check("pol1_colour", {s1_r, s1_g, s1_b}, {e_r, e_g, e_b});
  endtask

  // First line of the 800x525 instance; registered flags show count n_ce-1.
  task automatic default_checks();
    case (n_ce)
      640: begin check("def_hcount_640", d_hcount, 640); check("def_HBlank_639", d_HBlank, 0); end
      641: check("def_HBlank_640", d_HBlank, 1);
      656: check("def_Hsync_655", d_Hsync, 1);
      657: check("def_Hsync_656", d_Hsync, 0);
      752: check("def_Hsync_751", d_Hsync, 0);
      753: check("def_Hsync_752", d_Hsync, 1);
      800: begin
        check("def_hwrap_h", d_hcount, 0);
        check("def_hwrap_v", d_vcount, 1);
        check("def_HBlank_799", d_HBlank, 1);
        check("def_VBlank_line0", d_VBlank, 0);
        check("def_Vsync_line0", d_Vsync, 1);
      end
      801: check("def_HBlank_0", d_HBlank, 0);
      default: ;
    endcase
  endtask

  task automatic reset_values(input string tag);
    check({tag, "_s0_counts"}, {s0_hcount, s0_vcount}, 20'h0);
    check({tag, "_s0_blank"}, {s0_HBlank, s0_VBlank}, 2'b11);
    check({tag, "_s0_sync"}, {s0_Hsync, s0_Vsync}, 2'b11);
    check({tag, "_s0_colour"}, {s0_r, s0_g, s0_b}, 12'h0);
    check({tag, "_s0_tick"}, s0_tick, 0);
    check({tag, "_s1_sync"}, {s1_Hsync, s1_Vsync}, 2'b00);
    check({tag, "_s1_blank"}, {s1_HBlank, s1_VBlank}, 2'b11);
    check({tag, "_def_counts"}, {d_hcount, d_vcount}, 20'h0);
    check({tag, "_def_sync"}, {d_Hsync, d_Vsync}, 2'b11);
    check({tag, "_def_blank"}, {d_HBlank, d_VBlank}, 2'b11);
    check({tag, "_def_colour"}, {d_r, d_g, d_b}, 12'h0);
  endtask

  initial begin
    int hs_low, vs_low, lit, misalign;
    bit found;
    reset  = 1'b1;
    pix_ce = 1'b0;
    pix_r  = 4'h0; pix_g = 4'h0; pix_b = 4'h0;
    clk_n = 0; last_tick = -1; n_ticks = 0; exp_interval = 176;
    model_reset();

    // Reset holds regardless of pix_ce.
    repeat (3) @(negedge clk);
    reset_values("rst_ce0");
    pix_ce = 1'b1;
    pix_r = 4'h7; pix_g = 4'h7; pix_b = 4'h7;
    @(posedge clk);
    @(negedge clk);
    reset_values("rst_ce1");

    // Free run, pix_ce=1: two small frames tallied, default first line probed.
    reset = 1'b0;
    hs_low = 0; vs_low = 0; lit = 0; misalign = 0;
    for (int i = 0; i < 820; i++) begin
      step(1'b1);
      default_checks();
      if (i < 352) begin
        if (s0_Hsync == 1'b0) hs_low++;
        if (s0_Vsync == 1'b0) vs_low++;
        if (s0_b == 4'hF) lit++;
        if ((s0_b == 4'hF) != (!s0_HBlank && !s0_VBlank)) misalign++;
      end
    end
    check("hsync_low_2frames", hs_low, 66);
    check("vsync_low_2frames", vs_low, 64);
    check("lit_pixels_2frames", lit, 96);
    check("blank_colour_align", misalign, 0);
    check("ticks_ce_full", n_ticks, 4);

    // pix_ce one cycle in four: outputs freeze between enables, frame = 704 clks.
    last_tick = -1; n_ticks = 0; exp_interval = 704;
    for (int i = 0; i < 1408; i++) begin
      step((i % 4) == 0);
    end
    check("ticks_ce_quarter", n_ticks, 2);

    // Mid-frame reset while both sync pulses are active.
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      step(1'b1);
      if (mh == 11 && mv == 7) found = 1'b1;
    end
    check("reached_sync_point", found, 1);
    check("pre_reset_Hsync", s0_Hsync, 0);
    check("pre_reset_Vsync", s0_Vsync, 0);
    #2 reset = 1'b1;
    #1;
    reset_values("async_rst");
    @(posedge clk);
    @(negedge clk);
    reset_values("async_rst_held");

    reset = 1'b0;
    model_reset();
    step(1'b1);
    check("first_pix_HBlank", s0_HBlank, 0);
    check("first_pix_VBlank", s0_VBlank, 0);
    check("first_pix_colour", {s0_r, s0_g, s0_b}, 12'h5AF);
    check("first_pix_hcount", s0_hcount, 1);
    check("first_pix_def_colour", {d_r, d_g, d_b}, 12'h5AF);
    check("first_pix_def_blank", {d_HBlank, d_VBlank}, 2'b00);
    check("first_pix_pol1_sync", {s1_Hsync, s1_Vsync}, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
